// File: rtl/scope_frame_packer_if.sv
// Output word stream from the frame packer towards the Ethernet packer.
interface scope_frame_packer_if #(
   parameter int unsigned P_OUT_W = 8
) ();
   logic [P_OUT_W-1:0] o_data;
   logic               o_vld;
   logic               o_last;
   logic               i_ready;

   modport master (output o_data, output o_vld, output o_last, input i_ready);
   modport slave  (input o_data, input o_vld, input o_last, output i_ready);
endinterface

// File: rtl/scope_frame_packer.sv
// Scope frame packer: reduces ADC samples, buffers them and emits
// P_SEND_DATA-sample frames followed by an 8-word measurement trailer.
module scope_frame_packer #(
   parameter int unsigned P_ADC_W      = 12,
   parameter int unsigned P_OUT_W      = 8,
   parameter int unsigned P_SEND_DATA  = 1000,
   parameter int unsigned P_FIFO_DEPTH = 1024,
   parameter int unsigned P_MEAS_OFS   = 2048
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_round,
   input  logic [P_ADC_W-1:0] i_smp_data,
   input  logic               i_smp_vld,
   input  logic               i_smp_last,
   input  logic [31:0]        i_meas_freq,
   input  logic [P_ADC_W-1:0] i_meas_max,
   input  logic [P_ADC_W-1:0] i_meas_min,
   input  logic               i_meas_vld,
   input  logic               i_clr,
   scope_frame_packer_if.master m_out,
   output logic               o_ovf,
   output logic               o_short
);

   localparam int unsigned S      = P_ADC_W - P_OUT_W;
   localparam int unsigned AW     = $clog2(P_FIFO_DEPTH);
   localparam int unsigned PTR_W  = AW + 1;
   localparam int unsigned CNT_W  = $clog2(P_SEND_DATA + 1);
   localparam int unsigned E_W    = P_OUT_W + 1;
   localparam int unsigned TIDX_W = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TRAIL} state_t;

   // ---------------------------------------------------------------
   // Sample reduction
   // ---------------------------------------------------------------
   logic [P_OUT_W-1:0] red_word;

   if (S == 0) begin : g_noreduce
      assign red_word = i_smp_data;
   end else begin : g_reduce
      localparam int unsigned SUM_W = P_ADC_W + 1;
      logic [SUM_W-1:0] rnd_sum;
      logic [P_OUT_W:0] rnd_q;

      assign rnd_sum = {1'b0, i_smp_data} + (SUM_W'(1) << (S - 1));
      assign rnd_q   = rnd_sum[P_ADC_W:S];

      // Truncate or round half-up, saturating on carry out of the top bit
      always_comb begin
         red_word = i_smp_data[P_ADC_W-1:S];
         if (i_round) begin
            if (rnd_q[P_OUT_W]) red_word = '1;
            else                red_word = rnd_q[P_OUT_W-1:0];
         end
      end
   end

   // ---------------------------------------------------------------
   // Measurement registers (offset applied modulo 2^P_ADC_W)
   // ---------------------------------------------------------------
   logic [31:0]        meas_freq;
   logic [P_ADC_W-1:0] meas_max;
   logic [P_ADC_W-1:0] meas_min;

   // Latch the latest measurement update
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         meas_freq <= '0;
         meas_max  <= '0;
         meas_min  <= '0;
      end else if (i_meas_vld) begin
         meas_freq <= i_meas_freq;
         meas_max  <= i_meas_max + P_ADC_W'(P_MEAS_OFS);
         meas_min  <= i_meas_min + P_ADC_W'(P_MEAS_OFS);
      end
   end

   // ---------------------------------------------------------------
   // Sample FIFO of {tag, word}
   // ---------------------------------------------------------------
   logic [E_W-1:0]     mem [P_FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               fifo_empty;
   logic               fifo_full;
   logic [E_W-1:0]     rd_entry;
   logic               rd_tag;
   logic [P_OUT_W-1:0] rd_word;
   logic               push;
   logic               pop;
   logic               tag;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = ((wr_ptr - rd_ptr) == PTR_W'(P_FIFO_DEPTH));
   assign rd_entry   = mem[rd_ptr[AW-1:0]];
   assign rd_tag     = rd_entry[P_OUT_W];
   assign rd_word    = rd_entry[P_OUT_W-1:0];

   // Storage array; contents are don't-care while the pointers say empty
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {tag, red_word};
   end

   // FIFO pointers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // ---------------------------------------------------------------
   // Writer: frame counting, pending trailer snapshot, drop detection
   // ---------------------------------------------------------------
   logic               frame_open;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               at_full;
   logic               open_new;
   logic               pend_full;
   logic [31:0]        pend_freq;
   logic [P_ADC_W-1:0] pend_max;
   logic [P_ADC_W-1:0] pend_min;
   logic               snap_take;

   assign push     = i_smp_vld & ~fifo_full & (frame_open | ~pend_full);
   assign cnt_inc  = cnt + CNT_W'(1);
   assign at_full  = (cnt_inc == CNT_W'(P_SEND_DATA));
   assign tag      = at_full | i_smp_last;
   assign open_new = push & ~frame_open;

   // Frame open flag and sample count within the frame
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         frame_open <= 1'b0;
         cnt        <= '0;
      end else if (push) begin
         if (tag) begin
            frame_open <= 1'b0;
            cnt        <= '0;
         end else begin
            frame_open <= 1'b1;
            cnt        <= cnt_inc;
         end
      end
   end

   // Pending snapshot: taken when a frame opens, released when its tag pops
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend_full <= 1'b0;
         pend_freq <= '0;
         pend_max  <= '0;
         pend_min  <= '0;
      end else begin
         if (snap_take) pend_full <= 1'b0;
         if (open_new) begin
            pend_full <= 1'b1;
            pend_freq <= meas_freq;
            pend_max  <= meas_max;
            pend_min  <= meas_min;
         end
      end
   end

   // Sticky status; a set event wins over a clear in the same cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_ovf   <= 1'b0;
         o_short <= 1'b0;
      end else begin
         if (i_smp_vld & ~push) o_ovf <= 1'b1;
         else if (i_clr)        o_ovf <= 1'b0;
         if (push & i_smp_last & ~at_full) o_short <= 1'b1;
         else if (i_clr)                   o_short <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Trailer register and word select
   // ---------------------------------------------------------------
   logic [31:0]        tr_freq;
   logic [P_ADC_W-1:0] tr_max;
   logic [P_ADC_W-1:0] tr_min;
   logic [P_OUT_W-1:0] trail_word;

   // Frozen trailer for the frame currently being emitted
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tr_freq <= '0;
         tr_max  <= '0;
         tr_min  <= '0;
      end else if (snap_take) begin
         tr_freq <= pend_freq;
         tr_max  <= pend_max;
         tr_min  <= pend_min;
      end
   end

   logic [TIDX_W-1:0] tidx_q;
   logic [TIDX_W-1:0] tidx_d;

   // Trailer word for the current index
   always_comb begin
      trail_word = '0;
      case (tidx_q[2:0])
         3'd0: trail_word = P_OUT_W'(tr_freq[31:24]);
         3'd1: trail_word = P_OUT_W'(tr_freq[23:16]);
         3'd2: trail_word = P_OUT_W'(tr_freq[15:8]);
         3'd3: trail_word = P_OUT_W'(tr_freq[7:0]);
         3'd4: trail_word = P_OUT_W'(tr_max >> 8);
         3'd5: trail_word = P_OUT_W'(tr_max[7:0]);
         3'd6: trail_word = P_OUT_W'(tr_min >> 8);
         3'd7: trail_word = P_OUT_W'(tr_min[7:0]);
         default: trail_word = '0;
      endcase
   end

   // ---------------------------------------------------------------
   // Output FSM
   // ---------------------------------------------------------------
   state_t             state_q;
   state_t             state_d;
   logic [P_OUT_W-1:0] data_q;
   logic               vld_q;
   logic               last_q;
   logic               load_ok;
   logic               take;
   logic               ld;
   logic [P_OUT_W-1:0] ld_word;
   logic               ld_last;
   logic               drop;

   assign load_ok = ~vld_q | m_out.i_ready;

   // State and trailer index registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         tidx_q  <= '0;
      end else begin
         state_q <= state_d;
         tidx_q  <= tidx_d;
      end
   end

   // Next state and output-register load decisions
   always_comb begin
      state_d   = state_q;
      tidx_d    = tidx_q;
      take      = 1'b0;
      pop       = 1'b0;
      ld        = 1'b0;
      ld_word   = '0;
      ld_last   = 1'b0;
      drop      = 1'b0;
      snap_take = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (load_ok) begin
               if (!fifo_empty) take = 1'b1;
               else             drop = 1'b1;
            end
         end
         ST_TRAIL: begin
            if (load_ok) begin
               if (tidx_q != TIDX_W'(8)) begin
                  ld      = 1'b1;
                  ld_word = trail_word;
                  ld_last = (tidx_q == TIDX_W'(7));
                  tidx_d  = tidx_q + TIDX_W'(1);
               end else if (!fifo_empty) begin
                  take = 1'b1;
               end else begin
                  drop    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pop a data word into the output register; a tagged word ends the frame
      if (take) begin
         pop     = 1'b1;
         ld      = 1'b1;
         ld_word = rd_word;
         ld_last = 1'b0;
         if (rd_tag) begin
            state_d   = ST_TRAIL;
            tidx_d    = '0;
            snap_take = 1'b1;
         end else begin
            state_d = ST_DATA;
         end
      end
   end

   // Registered output stream; held while stalled
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         data_q <= '0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
      end else if (ld) begin
         data_q <= ld_word;
         vld_q  <= 1'b1;
         last_q <= ld_last;
      end else if (drop) begin
         vld_q  <= 1'b0;
         last_q <= 1'b0;
      end
   end

   assign m_out.o_data = data_q;
   assign m_out.o_vld  = vld_q;
   assign m_out.o_last = last_q;

endmodule

// File: tb/tb_scope_frame_packer.sv
// Scoreboard bench for scope_frame_packer (16-sample frames, 8-deep FIFO).
module tb_scope_frame_packer;

   logic        i_clk;
   logic        i_rst;
   logic        i_round;
   logic [11:0] i_smp_data;
   logic        i_smp_vld;
   logic        i_smp_last;
   logic [31:0] i_meas_freq;
   logic [11:0] i_meas_max;
   logic [11:0] i_meas_min;
   logic        i_meas_vld;
   logic        i_clr;
   logic        o_ovf;
   logic        o_short;

   scope_frame_packer_if #(.P_OUT_W(8)) s_if ();

   scope_frame_packer #(
      .P_ADC_W(12), .P_OUT_W(8), .P_SEND_DATA(16), .P_FIFO_DEPTH(8), .P_MEAS_OFS(2048)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_round(i_round),
      .i_smp_data(i_smp_data), .i_smp_vld(i_smp_vld), .i_smp_last(i_smp_last),
      .i_meas_freq(i_meas_freq), .i_meas_max(i_meas_max), .i_meas_min(i_meas_min),
      .i_meas_vld(i_meas_vld), .i_clr(i_clr),
      .m_out(s_if), .o_ovf(o_ovf), .o_short(o_short)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_hs  = 0;
   int rdy_mode = 0;

   logic [8:0] exp_q [$];
   logic [8:0] mon_e;

   bit         stall_prev = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;

   bit lat_arm  = 1'b0;
   int lat_t0   = 0;
   int lat_meas = -1;

   // Overflow-phase model: in-order subsequence of the ramp, 16 per frame
   bit         ovf_mode = 1'b0;
   bit         ovf_done = 1'b0;
   bit         ovf_end  = 1'b0;
   int         ovf_prev = -1;
   int         ovf_k    = 0;
   int         ovf_trl  = -1;
   int         ovf_ndata = 0;
   logic [7:0] trl_ovf [8];

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic ovf_check();
      bit ok;
      if (ovf_trl >= 0) begin
         chk("ovf_trailer", {s_if.o_last, s_if.o_data}, {ovf_trl == 7, trl_ovf[ovf_trl]});
         ovf_trl++;
         if (ovf_trl == 8) begin
            ovf_trl = -1;
            ovf_k   = 0;
            if (ovf_end) begin
               ovf_mode = 1'b0;
               ovf_done = 1'b1;
            end
         end
      end else begin
         ovf_ndata++;
         if (s_if.o_data == 8'hFF)  ok = 1'b1;
         else if (ovf_prev < 0)     ok = (s_if.o_data == 8'h00);
         else                       ok = (int'(s_if.o_data) > ovf_prev) && (s_if.o_data <= 8'd47);
         ok = ok && (s_if.o_last == 1'b0);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL ovf_data: got %0h last=%0b after %0h", s_if.o_data, s_if.o_last, ovf_prev);
         end
         ovf_prev = int'(s_if.o_data);
         ovf_k++;
         if (s_if.o_data == 8'hFF) ovf_end = 1'b1;
         if (ovf_k == 16 || s_if.o_data == 8'hFF) ovf_trl = 0;
      end
   endtask

   // Monitor: stall stability, latency capture, scoreboard pop on handshake
   always @(negedge i_clk) begin
      if (i_rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_vld", s_if.o_vld, 1);
            chk("stall_word", {s_if.o_last, s_if.o_data}, {prev_last, prev_data});
         end
         if (lat_arm && s_if.o_vld) begin
            lat_meas = cyc - lat_t0 + 1;
            lat_arm  = 1'b0;
         end
         if (s_if.o_vld && s_if.i_ready) begin
            n_hs++;
            if (ovf_mode) begin
               ovf_check();
            end else if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %0h last=%0b want none", s_if.o_data, s_if.o_last);
            end else begin
               mon_e = exp_q.pop_front();
               chk("word", {s_if.o_last, s_if.o_data}, mon_e);
            end
         end
         stall_prev = s_if.o_vld && !s_if.i_ready;
         prev_data  = s_if.o_data;
         prev_last  = s_if.o_last;
      end
   end

   // Downstream ready: always 1, or 1-of-3 during the overflow phase
   initial begin
      int rc;
      rc = 0;
      s_if.i_ready = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         rc++;
         s_if.i_ready = (rdy_mode == 0) ? 1'b1 : (rc % 3 == 0);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input int w, input bit last);
      i_smp_data = 12'(w);
      i_smp_vld  = 1'b1;
      i_smp_last = last;
      @(posedge i_clk);
      #1;
      i_smp_vld  = 1'b0;
      i_smp_last = 1'b0;
   endtask

   task automatic send_ramp(input int first, input int n, input int last_at);
      for (int k = 0; k < n; k++) send((first + k) << 4, (k == last_at));
   endtask

   task automatic push_data(input int first, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back({1'b0, 8'(first + k)});
   endtask

   task automatic push_trl(input logic [63:0] w);
      for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), w[63 - 8*k -: 8]});
   endtask

   task automatic set_meas(input logic [31:0] f, input logic [11:0] mx, input logic [11:0] mn);
      i_meas_freq = f;
      i_meas_max  = mx;
      i_meas_min  = mn;
      i_meas_vld  = 1'b1;
      @(posedge i_clk);
      #1;
      i_meas_vld  = 1'b0;
   endtask

   task automatic pulse_clr();
      i_clr = 1'b1;
      @(posedge i_clk);
      #1;
      i_clr = 1'b0;
   endtask

   task automatic wait_drain(input int maxc);
      bit done;
      done = 1'b0;
      for (int i = 0; i < maxc && !done; i++) begin
         @(posedge i_clk);
         #1;
         if (exp_q.size() == 0 && !s_if.o_vld && !ovf_mode) done = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got pending=%0d want 0", exp_q.size());
      end
   endtask

   initial begin
      int base;
      bit hit;
      i_rst = 1'b1; i_round = 1'b0; i_smp_data = '0; i_smp_vld = 1'b0; i_smp_last = 1'b0;
      i_meas_freq = '0; i_meas_max = '0; i_meas_min = '0; i_meas_vld = 1'b0; i_clr = 1'b0;
      trl_ovf[0] = 8'h12; trl_ovf[1] = 8'h34; trl_ovf[2] = 8'h56; trl_ovf[3] = 8'h78;
      trl_ovf[4] = 8'h0F; trl_ovf[5] = 8'hFF; trl_ovf[6] = 8'h00; trl_ovf[7] = 8'h00;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_data", s_if.o_data, 0);
      chk("rst_vld", s_if.o_vld, 0);
      chk("rst_last", s_if.o_last, 0);
      chk("rst_ovf", o_ovf, 0);
      chk("rst_short", o_short, 0);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;

      // Ramp frame, truncation, trailer packing and first-word latency
      set_meas(32'h12345678, 12'h7FF, 12'h800);
      push_data(0, 16);
      push_trl(64'h12345678_0FFF_0000);
      send(0, 1'b0);
      lat_t0  = cyc;
      lat_arm = 1'b1;
      send_ramp(1, 15, -1);
      wait_drain(200);
      chk("latency_le3", (lat_meas >= 1 && lat_meas <= 3), 1);

      // Rounding with saturation, in a 3-sample early-closed frame
      i_round = 1'b1;
      exp_q.push_back(9'h000);
      exp_q.push_back(9'h001);
      exp_q.push_back(9'h0FF);
      push_trl(64'h12345678_0FFF_0000);
      send(12'h007, 1'b0);
      send(12'h008, 1'b0);
      send(12'hFF8, 1'b1);
      wait_drain(200);
      i_round = 1'b0;
      chk("short_after_round", o_short, 1);
      pulse_clr();
      chk("short_clr", o_short, 0);

      // Early end on the 5th sample, then a full-length frame
      push_data(8'h20, 5);
      push_trl(64'h12345678_0FFF_0000);
      send_ramp(8'h20, 5, 4);
      wait_drain(200);
      chk("short_set", o_short, 1);
      push_data(8'h30, 16);
      push_trl(64'h12345678_0FFF_0000);
      send_ramp(8'h30, 16, -1);
      wait_drain(200);
      chk("no_ovf_yet", o_ovf, 0);

      // Backpressure 1-of-3 with a sample every cycle: drops and overflow
      ovf_prev = -1; ovf_k = 0; ovf_trl = -1; ovf_end = 1'b0; ovf_done = 1'b0; ovf_ndata = 0;
      ovf_mode = 1'b1;
      rdy_mode = 1;
      send_ramp(0, 48, -1);
      rdy_mode = 0;
      repeat (60) @(posedge i_clk);
      #1;
      send(12'hFF0, 1'b1);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge i_clk);
            #1;
            seen = ovf_done;
         end
         chk("ovf_phase_done", seen, 1);
         ovf_mode = 1'b0;
      end
      wait_drain(200);
      chk("ovf_set", o_ovf, 1);
      chk("ovf_dropped", (ovf_ndata < 49), 1);

      // Measurement update mid-frame only affects the following frame
      push_data(8'h40, 16);
      push_trl(64'h12345678_0FFF_0000);
      send_ramp(8'h40, 4, -1);
      set_meas(32'h12345678, 12'h100, 12'h800);
      send_ramp(8'h44, 12, -1);
      wait_drain(200);
      push_data(8'h70, 16);
      push_trl(64'h12345678_0900_0000);
      send_ramp(8'h70, 16, -1);
      wait_drain(200);
      pulse_clr();
      chk("clr_ovf", o_ovf, 0);
      chk("clr_short", o_short, 0);

      // Reset while trailer word 3 is presented
      base = n_hs;
      push_data(8'h50, 16);
      push_trl(64'h12345678_0900_0000);
      send_ramp(8'h50, 16, -1);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (n_hs == base + 18) hit = 1'b1;
         else begin
            @(posedge i_clk);
            #1;
         end
      end
      chk("reach_trailer3", hit, 1);
      i_rst = 1'b1;
      exp_q.delete();
      @(negedge i_clk);
      chk("mid_rst_data", s_if.o_data, 0);
      chk("mid_rst_vld", s_if.o_vld, 0);
      chk("mid_rst_last", s_if.o_last, 0);
      chk("mid_rst_ovf", o_ovf, 0);
      chk("mid_rst_short", o_short, 0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;

      // Fresh frame after reset with modulo-wrapped minimum
      set_meas(32'hA5A50001, 12'h123, 12'hF00);
      push_data(8'h60, 16);
      push_trl(64'hA5A50001_0923_0700);
      send_ramp(8'h60, 16, -1);
      wait_drain(200);
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_ovf", o_ovf, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
